// File: rtl/fb_output_serializer.sv
// Captures one frame of NCH filter-bank words, rounds/saturates each to OUT_W bits,
// and streams them out one channel per ready/valid handshake.
module fb_output_serializer #(
    parameter int NCH   = 16,
    parameter int IN_W  = 39,
    parameter int OUT_W = 16,
    parameter int DROP  = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  capture,
    input  logic [NCH*IN_W-1:0]   filter_bus,
    output logic [OUT_W-1:0]      out_data,
    output logic [3:0]            out_chan,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [7:0]            sat_count
);

    localparam int CW = $clog2(NCH + 1);
    localparam logic [IN_W:0] HALF = {{(IN_W-DROP+1){1'b0}}, 1'b1, {(DROP-1){1'b0}}};

    typedef enum logic {IDLE, SEND} state_t;

    state_t             r_state;
    logic [3:0]         r_chan;
    logic [OUT_W-1:0]   r_bank [NCH];
    logic               r_overrun;
    logic [7:0]         r_sat;

    logic signed [IN_W:0] w_sum   [NCH];
    logic signed [IN_W:0] w_shift [NCH];
    logic [OUT_W-1:0]     w_conv  [NCH];
    logic [NCH-1:0]       w_clip;
    logic [CW-1:0]        w_nclip;
    logic [8:0]           w_sat_sum;
    logic                 w_xfer;
    logic                 w_final;
    logic                 w_load;
    logic                 w_drop;

    // Sum is one bit wider than the input so the rounding offset can never wrap.
    always_comb begin
        w_nclip = '0;
        for (int k = 0; k < NCH; k++) begin
            w_sum[k]   = $signed({filter_bus[k*IN_W+IN_W-1], filter_bus[k*IN_W +: IN_W]})
                       + $signed(HALF);
            w_shift[k] = w_sum[k] >>> DROP;
            w_clip[k]  = !((&w_shift[k][IN_W:OUT_W-1]) || !(|w_shift[k][IN_W:OUT_W-1]));
            if (w_clip[k])
                w_conv[k] = w_shift[k][IN_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                             : {1'b0, {(OUT_W-1){1'b1}}};
            else
                w_conv[k] = w_shift[k][OUT_W-1:0];
            w_nclip = w_nclip + CW'(w_clip[k]);
        end
    end

    assign w_sat_sum = {1'b0, r_sat} + 9'(w_nclip);
    assign w_xfer    = out_valid && out_ready;
    assign w_final   = w_xfer && (r_chan == 4'(NCH-1));
    assign w_load    = capture && ((r_state == IDLE) || w_final);
    assign w_drop    = capture && (r_state == SEND) && !w_final;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_chan    <= '0;
            r_overrun <= 1'b0;
            r_sat     <= '0;
            for (int k = 0; k < NCH; k++)
                r_bank[k] <= '0;
        end else if (clk_enable) begin
            if (w_load) begin
                r_state <= SEND;
                r_chan  <= '0;
                for (int k = 0; k < NCH; k++)
                    r_bank[k] <= w_conv[k];
                r_sat   <= w_sat_sum[8] ? 8'hFF : w_sat_sum[7:0];
            end else if (w_xfer) begin
                if (w_final)
                    r_state <= IDLE;
                else
                    r_chan <= r_chan + 4'd1;
            end
            // A dropped frame must stay visible even if software clears in the same cycle.
            if (w_drop)
                r_overrun <= 1'b1;
            else if (overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign out_valid = (r_state == SEND) && clk_enable;
    assign out_data  = r_bank[r_chan];
    assign out_chan  = r_chan;
    assign out_last  = out_valid && (r_chan == 4'(NCH-1));
    assign overrun   = r_overrun;
    assign sat_count = r_sat;

endmodule

// File: tb/tb_fb_output_serializer.sv
// Bench for fb_output_serializer: directed scenarios plus random traffic, checked
// against a queue-based model of the words still owed to the downstream consumer.
module tb_fb_output_serializer;

    localparam int NCH   = 16;
    localparam int IN_W  = 39;
    localparam int OUT_W = 16;
    localparam int DROP  = 18;

    logic                clock = 1'b0;
    logic                reset, clk_enable, capture, out_ready, overrun_clr;
    logic [NCH*IN_W-1:0] filter_bus;
    logic [OUT_W-1:0]    out_data;
    logic [3:0]          out_chan;
    logic                out_valid, out_last, overrun;
    logic [7:0]          sat_count;

    always #5 clock = ~clock;

    fb_output_serializer #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .DROP(DROP)) dut (
        .clock(clock), .reset(reset), .clk_enable(clk_enable), .capture(capture),
        .filter_bus(filter_bus), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .overrun(overrun), .overrun_clr(overrun_clr), .sat_count(sat_count)
    );

    typedef struct { int chan; longint data; } word_t;

    longint ch_val [NCH];
    word_t  q_exp[$];
    word_t  log_q[$];
    bit     m_ov;
    int     m_sat;
    int     n_chk, n_pass;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint round_shift(longint v);
        return (v + (longint'(1) <<< (DROP-1))) >>> DROP;
    endfunction

    function automatic longint conv(longint v);
        longint r = round_shift(v);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic bit clips(longint v);
        longint r = round_shift(v);
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic longint rand_val();
        longint x;
        case ($urandom_range(0, 2))
            0: x = longint'($urandom_range(0, 1 << 24)) - (1 << 23);
            1: begin
                x = (longint'(1) <<< 33) + longint'($urandom_range(0, 1 << 20)) - (1 << 19);
                if ($urandom_range(0, 1) == 1) x = -x;
            end
            default: begin
                x = {$urandom, $urandom};
                x = (x <<< 25) >>> 25;
            end
        endcase
        return x;
    endfunction

    // One clock: drive at negedge, compare against model, advance model, settle past posedge.
    task automatic cyc(bit rst, bit en, bit cap, bit rdy, bit clr);
        bit busy, xfer, fin, load;
        int nclip;
        @(negedge clock);
        reset = rst; clk_enable = en; capture = cap; out_ready = rdy; overrun_clr = clr;
        for (int k = 0; k < NCH; k++) filter_bus[k*IN_W +: IN_W] = ch_val[k][IN_W-1:0];
        #1;
        busy = (q_exp.size() > 0);
        check("out_valid", out_valid, en && busy);
        if (en && busy) begin
            check("out_data", longint'($signed(out_data)), q_exp[0].data);
            check("out_chan", out_chan, q_exp[0].chan);
            check("out_last", out_last, q_exp.size() == 1);
        end else begin
            check("out_last_idle", out_last, 0);
        end
        check("overrun", overrun, m_ov);
        check("sat_count", sat_count, m_sat);
        if (rst) begin
            q_exp.delete();
            m_ov = 0;
            m_sat = 0;
        end else if (en) begin
            xfer = busy && rdy;
            fin  = xfer && (q_exp.size() == 1);
            if (xfer) log_q.push_back(q_exp[0]);
            load = cap && (!busy || fin);
            if (load) begin
                q_exp.delete();
                nclip = 0;
                for (int k = 0; k < NCH; k++) begin
                    q_exp.push_back('{k, conv(ch_val[k])});
                    nclip += int'(clips(ch_val[k]));
                end
                m_sat = (m_sat + nclip > 255) ? 255 : m_sat + nclip;
            end else if (xfer) begin
                void'(q_exp.pop_front());
            end
            if (cap && !load) m_ov = 1;
            else if (clr)     m_ov = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 1, 0);
    endtask

    initial begin
        reset = 1; clk_enable = 0; capture = 0; out_ready = 0; overrun_clr = 0;
        filter_bus = '0;
        for (int k = 0; k < NCH; k++) ch_val[k] = 0;
        m_ov = 0; m_sat = 0; n_chk = 0; n_pass = 0;
        repeat (2) @(posedge clock);
        #1;
        clk_enable = 1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_chan", out_chan, 0);
        check("rst_last", out_last, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sat", sat_count, 0);

        // Frame order
        for (int k = 0; k < NCH; k++) ch_val[k] = longint'(k) <<< 18;
        log_q.delete();
        cyc(0, 1, 1, 1, 0);
        check("order_first_valid", out_valid, 1);
        drain(17);
        check("order_count", log_q.size(), 16);
        for (int k = 0; k < NCH && k < log_q.size(); k++) begin
            check("order_data", log_q[k].data, k);
            check("order_chan", log_q[k].chan, k);
        end

        // Rounding
        for (int k = 0; k < NCH; k++) ch_val[k] = 0;
        ch_val[0] = 'h1FFFF; ch_val[1] = 'h20000; ch_val[2] = -131072; ch_val[3] = -131073;
        log_q.delete();
        cyc(0, 1, 1, 1, 0);
        drain(17);
        if (log_q.size() >= 4) begin
            check("round_ch0", log_q[0].data, 0);
            check("round_ch1", log_q[1].data, 1);
            check("round_ch2", log_q[2].data, 0);
            check("round_ch3", log_q[3].data, -1);
        end else check("round_count", log_q.size(), 16);

        // Saturation
        ch_val[0] = longint'(1) <<< 33; ch_val[1] = -(longint'(1) <<< 38);
        ch_val[2] = 0; ch_val[3] = 0;
        log_q.delete();
        cyc(0, 1, 1, 1, 0);
        drain(17);
        check("sat_total", sat_count, 2);
        if (log_q.size() >= 2) begin
            check("sat_ch0", log_q[0].data, 32767);
            check("sat_ch1", log_q[1].data, -32768);
        end else check("sat_count_words", log_q.size(), 16);

        // Backpressure with a capture during the stall
        for (int k = 0; k < NCH; k++) ch_val[k] = longint'(k * 100) <<< 18;
        cyc(0, 1, 1, 0, 0);
        drain(3);
        check("stall_chan", out_chan, 3);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < NCH; k++) ch_val[k] = longint'(k * 7 + 1) <<< 18;
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("stall_hold_data", longint'($signed(out_data)), 300);
        check("stall_overrun", overrun, 1);
        cyc(0, 1, 0, 0, 1);
        check("overrun_clr", overrun, 0);
        log_q.delete();
        drain(14);
        check("stall_rest_count", log_q.size(), 13);
        foreach (log_q[i]) check("stall_old_frame", log_q[i].data, log_q[i].chan * 100);

        // Back-to-back frames
        for (int k = 0; k < NCH; k++) ch_val[k] = longint'(k + 50) <<< 18;
        cyc(0, 1, 1, 1, 0);
        drain(15);
        for (int k = 0; k < NCH; k++) ch_val[k] = longint'(k + 200) <<< 18;
        cyc(0, 1, 1, 1, 0);
        check("b2b_valid", out_valid, 1);
        check("b2b_chan", out_chan, 0);
        check("b2b_data", longint'($signed(out_data)), 200);
        check("b2b_overrun", overrun, 0);
        drain(17);

        // Reset mid-frame
        cyc(0, 1, 1, 1, 0);
        drain(7);
        check("mid_chan", out_chan, 7);
        cyc(1, 1, 0, 1, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_chan", out_chan, 0);
        drain(4);

        // Enable gap mid-frame
        for (int k = 0; k < NCH; k++) ch_val[k] = longint'(k + 9) <<< 18;
        cyc(0, 1, 1, 1, 0);
        drain(5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 1);
            check("en_gap_valid", out_valid, 0);
            check("en_gap_chan", out_chan, 5);
        end
        cyc(0, 1, 0, 1, 0);
        drain(11);

        // Set wins over clear
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 1);
        check("set_wins", overrun, 1);
        cyc(0, 1, 0, 1, 1);
        drain(16);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            bit cap;
            cap = ($urandom_range(0, 9) == 0);
            if (cap) for (int k = 0; k < NCH; k++) ch_val[k] = rand_val();
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, cap,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
